// File: rtl/mod_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mod_add_arbiter
// Purpose  : Shares one (A + B) mod q adder among NREQ requesters, with a
//            one-entry result buffer that is tagged with the requester index.
// Options  : MOD_ADD_ARB_RR_EN selects round-robin arbitration. When it is
//            not defined, the block uses fixed priority (lowest index wins).
// Revision : 1.0 - initial release
// ============================================================================
module mod_add_arbiter #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 4,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      modulus,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [WIDTH-1:0]      res_data,
   output logic [IDW-1:0]        res_id
);

   logic             w_can_accept;
   logic             w_any;
   logic             w_accept;
   logic [IDW-1:0]   w_winner;
   logic [IDW-1:0]   w_ptr;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH-1:0] w_mod;

`ifdef MOD_ADD_ARB_RR_EN
   logic [IDW-1:0]   r_ptr;
   assign w_ptr = r_ptr;
`else
   assign w_ptr = '0;
`endif

   assign w_can_accept = ~res_valid | res_ready;

   // Scan upward from the pointer and wrap around; the first valid requester wins.
   always_comb begin
      int idx;
      idx      = 0;
      w_any    = 1'b0;
      w_winner = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(w_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!w_any && req_valid[idx]) begin
            w_any    = 1'b1;
            w_winner = IDW'(idx);
         end
      end
   end

   generate
      for (genvar i = 0; i < NREQ; i++) begin : g_ready
         assign req_ready[i] = w_any && (w_winner == IDW'(i)) && w_can_accept && !rst;
      end
   endgenerate

   assign w_accept = w_any & w_can_accept;

   always_comb begin
      w_a = '0;
      w_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_winner == IDW'(i)) begin
            w_a = req_a[i*WIDTH +: WIDTH];
            w_b = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   // The MSB of the (WIDTH+1)-bit difference is a borrow, which means sum < q.
   assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
   assign w_diff = w_sum - {1'b0, modulus};
   assign w_mod  = w_diff[WIDTH] ? w_sum[WIDTH-1:0] : w_diff[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= '0;
      end else if (w_accept) begin
         res_valid <= 1'b1;
         res_data  <= w_mod;
         res_id    <= w_winner;
      end else if (res_ready) begin
         res_valid <= 1'b0;
      end
   end

`ifdef MOD_ADD_ARB_RR_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (w_accept) begin
         r_ptr <= (w_winner == IDW'(NREQ-1)) ? '0 : w_winner + IDW'(1);
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mod_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_add_arbiter
// Purpose  : Scoreboard bench for mod_add_arbiter. It follows MOD_ADD_ARB_RR_EN
//            in the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_add_arbiter;
   localparam int WIDTH = 32;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [WIDTH-1:0]      modulus;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_ready;
   logic                  res_valid;
   logic                  res_ready;
   logic [WIDTH-1:0]      res_data;
   logic [IDW-1:0]        res_id;

   always #5 clk = ~clk;

   mod_add_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .modulus   (modulus),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_id    (res_id)
   );

   typedef struct packed {
      logic [IDW-1:0]   id;
      logic [WIDTH-1:0] data;
   } res_t;

   res_t sb[$];
   bit   m_valid = 1'b0;
   int   m_ptr   = 0;
   int   err_cnt = 0;
   int   chk_cnt = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] q);
      logic [63:0] s;
      s = 64'(a) + 64'(b);
      if (s >= 64'(q)) s = s - 64'(q);
      return s[WIDTH-1:0];
   endfunction

   task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
   endtask

   // Drive one cycle at the falling edge. Check the outputs, then advance the model.
   task automatic cycle(input logic [NREQ-1:0] v, input logic rr, input logic r);
      int              win;
      logic [NREQ-1:0] exp_rdy;
      res_t            e;
      req_valid = v;
      res_ready = rr;
      rst       = r;
      #1;
      win = -1;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (m_ptr + k) % NREQ;
         if (win < 0 && v[idx]) win = idx;
      end
      exp_rdy = '0;
      if (!r && win >= 0 && (!m_valid || rr)) exp_rdy[win] = 1'b1;
      check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
      check_eq("res_valid", 64'(res_valid), 64'(m_valid));
      if (m_valid && sb.size() > 0) begin
         e = sb[0];
         check_eq("res_data", 64'(res_data), 64'(e.data));
         check_eq("res_id", 64'(res_id), 64'(e.id));
         if (rr) void'(sb.pop_front());
      end
      if (r) begin
         m_valid = 1'b0;
         m_ptr   = 0;
         sb.delete();
      end else if (exp_rdy != '0) begin
         e.id   = IDW'(win);
         e.data = mod_add(req_a[win*WIDTH +: WIDTH], req_b[win*WIDTH +: WIDTH], modulus);
         sb.push_back(e);
         m_valid = 1'b1;
`ifdef MOD_ADD_ARB_RR_EN
         m_ptr = (win + 1) % NREQ;
`endif
      end else if (rr) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst       = 1'b1;
      modulus   = 32'd17;
      req_valid = '1;
      res_ready = 1'b1;
      req_a     = '0;
      req_b     = '0;
      @(negedge clk);

      // Keep reset asserted while every requester is valid.
      cycle(4'b1111, 1'b1, 1'b1);
      cycle(4'b1111, 1'b1, 1'b1);
      check_eq("rst_data", 64'(res_data), 64'd0);
      check_eq("rst_id", 64'(res_id), 64'd0);
      cycle(4'b1111, 1'b1, 1'b0);
      cycle(4'b0000, 1'b1, 1'b0);

      // q = 17, requester 2 alone.
      set_op(2, 32'd9, 32'd12);  cycle(4'b0100, 1'b1, 1'b0);
      set_op(2, 32'd3, 32'd5);   cycle(4'b0100, 1'b1, 1'b0);
      set_op(2, 32'd16, 32'd16); cycle(4'b0100, 1'b1, 1'b0);
      cycle(4'b0000, 1'b1, 1'b0);

      // The sum carries into bit 32.
      modulus = 32'hFFFF_FFFB;
      set_op(0, 32'hFFFF_FFFA, 32'hFFFF_FFFA);
      cycle(4'b0001, 1'b1, 1'b0);
      cycle(4'b0000, 1'b1, 1'b0);

      // All requesters stay valid, starting from a freshly reset pointer.
      modulus = 32'd17;
      for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 1), 32'(2 * i + 3));
      cycle(4'b0000, 1'b1, 1'b1);
      for (int n = 0; n < 6; n++) cycle(4'b1111, 1'b1, 1'b0);
      cycle(4'b0000, 1'b1, 1'b0);

      // Backpressure: buffer id 1 while id 3 waits, then drain and accept together.
      cycle(4'b0001, 1'b1, 1'b0);
      cycle(4'b0000, 1'b1, 1'b0);
      cycle(4'b1010, 1'b0, 1'b0);
      for (int n = 0; n < 3; n++) cycle(4'b1000, 1'b0, 1'b0);
      cycle(4'b1000, 1'b1, 1'b0);
      cycle(4'b0000, 1'b1, 1'b0);

      // Reset while a result is buffered.
      cycle(4'b0010, 1'b0, 1'b0);
      cycle(4'b1111, 1'b0, 1'b1);
      cycle(4'b1100, 1'b1, 1'b0);
      cycle(4'b0000, 1'b1, 1'b0);

      // Random traffic.
      modulus = 32'hFFFF_FFF1;
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < NREQ; i++)
            set_op(i, $urandom % modulus, $urandom % modulus);
         cycle(NREQ'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0));
      end
      cycle(4'b0000, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end
endmodule
`default_nettype wire
